avalon_input_pio_irq: RTL and testbench



---
 rtl/avalon_input_pio_irq_pkg.sv | 14 +
 rtl/avalon_input_pio_irq_if.sv | 14 +
 rtl/avalon_input_pio_irq_sync_edge.sv | 61 ++++++
 rtl/avalon_input_pio_irq.sv | 77 +++++++
 tb/tb_avalon_input_pio_irq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/avalon_input_pio_irq_pkg.sv
// Shared constants for the Avalon input PIO: register word addresses and
// the encodings of the EDGE_TYPE parameter.
package pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_DIR     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/avalon_input_pio_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO; readdata is driven by the slave.
interface avalon_input_pio_irq_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
   modport master (output address, chipselect, read_n, write_n, writedata, input readdata);

endinterface

// File: rtl/avalon_input_pio_irq_sync_edge.sv
// Input synchronizer, previous-sample register, post-reset primer and
// per-bit edge detector for the input PIO.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edge_pulse_o
);

   localparam int PRIME_MAX = SYNC_STAGES + 1;
   localparam int CW        = $clog2(PRIME_MAX + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [CW-1:0]    prime_q, prime_d;
   logic             primed;
   logic [WIDTH-1:0] edge_raw;

   // NOTE: the synchronizer array is small flop storage, not RAM, so every
   // entry is cleared on reset; a RAM-style array would be left unreset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q  <= '0;
         prime_q <= '0;
      end else begin
         // NOTE: non-blocking so every stage shifts from its pre-edge value.
         sync_q[0] <= in_port_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q  <= sync_o;
         prime_q <= prime_d;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

   // Edges stay masked until the chain and prev_q hold real samples, so an
   // input already high at reset release is not seen as a rising edge.
   assign primed  = (prime_q == CW'(PRIME_MAX));
   assign prime_d = primed ? prime_q : prime_q + CW'(1);

   // NOTE: default first so no path through the case leaves edge_raw unassigned.
   always_comb begin
      edge_raw = sync_o & ~prev_q;
      case (EDGE_TYPE)
         EDGE_FALLING: edge_raw = ~sync_o & prev_q;
         EDGE_ANY:     edge_raw = sync_o ^ prev_q;
         default:      ;
      endcase
   end

   assign edge_pulse_o = primed ? edge_raw : '0;

endmodule

// File: rtl/avalon_input_pio_irq.sv
// Avalon-MM input PIO with W1C edge capture and masked level interrupt;
// readdata and irq are both registered.
module avalon_input_pio_irq
   import pio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   avalon_input_pio_irq_if.slave  bus,
   input  logic [WIDTH-1:0]       in_port,
   output logic                   irq
);

   logic [WIDTH-1:0] sync_val, edge_pulse;
   logic [WIDTH-1:0] capture_q, capture_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] clr;
   logic [31:0]      readdata_q, readdata_d, rd_word;
   logic             irq_q, irq_d;
   logic             wr_en, rd_en;

   pio_sync_edge #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_port_i    (in_port),
      .sync_o       (sync_val),
      .edge_pulse_o (edge_pulse)
   );

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign rd_en = bus.chipselect & ~bus.read_n;

   always_comb begin
      mask_d = mask_q;
      clr    = '0;
      if (wr_en && bus.address == ADDR_IRQMASK) mask_d = bus.writedata[WIDTH-1:0];
      if (wr_en && bus.address == ADDR_EDGECAP) clr    = bus.writedata[WIDTH-1:0];

      // OR-ing the new edges after the clear makes a same-cycle set win.
      capture_d = (capture_q & ~clr) | edge_pulse;
      irq_d     = |(capture_q & mask_q);

      rd_word = '0;
      case (bus.address)
         ADDR_DATA:    rd_word[WIDTH-1:0] = sync_val;
         ADDR_IRQMASK: rd_word[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: rd_word[WIDTH-1:0] = capture_q;
         default:      ;  // direction register reads as all-input
      endcase
      readdata_d = rd_en ? rd_word : readdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         capture_q  <= '0;
         mask_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         capture_q  <= capture_d;
         mask_q     <= mask_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_input_pio_irq.sv
// Directed scoreboard bench: a rising-edge PIO (SYNC_STAGES=2) and an
// any-edge PIO (SYNC_STAGES=3) share one Avalon master.
module tb_avalon_input_pio_irq;
   import pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect, read_n, write_n;
   logic [31:0] writedata;
   logic [31:0] in0, in1;
   logic [31:0] rdata0, rdata1;
   logic        irq0, irq1;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  passes = 0;
   int  fails  = 0;

   avalon_input_pio_irq_if bus0 ();
   avalon_input_pio_irq_if bus1 ();

   assign bus0.address    = address;
   assign bus0.chipselect = chipselect;
   assign bus0.read_n     = read_n;
   assign bus0.write_n    = write_n;
   assign bus0.writedata  = writedata;
   assign bus1.address    = address;
   assign bus1.chipselect = chipselect;
   assign bus1.read_n     = read_n;
   assign bus1.write_n    = write_n;
   assign bus1.writedata  = writedata;
   assign rdata0 = bus0.readdata;
   assign rdata1 = bus1.readdata;

   avalon_input_pio_irq #(.WIDTH(32), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0));

   avalon_input_pio_irq #(.WIDTH(32), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(3)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; the strobe is sampled on the following posedge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
      sb_t e;
      address = a; chipselect = 1'b1; read_n = 1'b0;
      e.tag = tag; e.sel = sel; e.exp = exp;
      sb_q.push_back(e);
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
      e = sb_q.pop_front();
      check(e.tag, (e.sel == 0) ? rdata0 : rdata1, e.exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b1; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
      write_n = 1'b1; writedata = 32'h0; in0 = 32'h0000_000F; in1 = 32'h0;
      #1 reset_n = 1'b0;
      #1;
      check("rst_irq0",   32'(irq0), 32'h0);
      check("rst_rdata0", rdata0,    32'h0);
      check("rst_rdata1", rdata1,    32'h0);
      cycles(3);
      reset_n = 1'b1;
      cycles(10);

      // Inputs high at reset release must not register as edges.
      rd(0, ADDR_EDGECAP, 32'h0,         "prime_no_cap");
      rd(0, ADDR_DATA,    32'h0000_000F, "data_live");

      in0 = 32'h3; cycles(6);
      rd(0, ADDR_EDGECAP, 32'h0, "fall_ignored");

      // Rising bit 2: capture must appear exactly 3 edges after the change.
      in0 = 32'h7; cycles(2);
      rd(0, ADDR_EDGECAP, 32'h0, "rise_not_early");
      rd(0, ADDR_EDGECAP, 32'h4, "rise_latency");
      in0 = 32'h3; cycles(6);
      rd(0, ADDR_EDGECAP, 32'h4, "fall_keeps_cap");

      wr(ADDR_IRQMASK, 32'h4);
      check("irq_not_early", 32'(irq0), 32'h0);
      cycles(1);
      check("irq_set", 32'(irq0), 32'h1);
      wr(ADDR_EDGECAP, 32'h4);
      check("irq_lag", 32'(irq0), 32'h1);
      cycles(1);
      check("irq_clear", 32'(irq0), 32'h0);
      rd(0, ADDR_EDGECAP, 32'h0, "w1c_clear");

      // Same-cycle set and W1C clear on bit 0.
      in0 = 32'h2; cycles(6);
      rd(0, ADDR_EDGECAP, 32'h0, "fall0_ignored");
      in0 = 32'h3; cycles(2);
      wr(ADDR_EDGECAP, 32'h1);
      rd(0, ADDR_EDGECAP, 32'h1, "set_wins");
      check("masked_no_irq", 32'(irq0), 32'h0);
      wr(ADDR_EDGECAP, 32'h0);
      rd(0, ADDR_EDGECAP, 32'h1, "w1c_zero_noop");
      wr(ADDR_EDGECAP, 32'h1);
      rd(0, ADDR_EDGECAP, 32'h0, "w1c_bit0");
      rd(0, ADDR_IRQMASK, 32'h4, "mask_rb");

      // Any-edge instance: both directions of bit 7 latch.
      in1 = 32'h80; cycles(8);
      rd(1, ADDR_EDGECAP, 32'h80, "any_rise");
      wr(ADDR_EDGECAP, 32'h80);
      rd(1, ADDR_EDGECAP, 32'h0,  "any_clr");
      in1 = 32'h0; cycles(8);
      rd(1, ADDR_EDGECAP, 32'h80, "any_fall");
      wr(ADDR_DATA, 32'hFFFF_FFFF);
      wr(ADDR_DIR,  32'hFFFF_FFFF);
      rd(1, ADDR_DATA,    32'h0,  "data1_wr_ignored");
      rd(1, ADDR_DIR,     32'h0,  "dir1_reads0");
      rd(1, ADDR_EDGECAP, 32'h80, "cap1_after_ro_wr");
      rd(0, ADDR_DATA,    32'h3,  "data0_wr_ignored");
      rd(0, ADDR_DIR,     32'h0,  "dir0_reads0");

      // Build capture=5, mask=5, irq=1, then reset between clock edges.
      in0 = 32'h0; cycles(6);
      in0 = 32'h5; cycles(6);
      wr(ADDR_IRQMASK, 32'h5);
      cycles(1);
      check("pre_rst_irq", 32'(irq0), 32'h1);
      rd(0, ADDR_EDGECAP, 32'h5, "pre_rst_cap");
      rd(0, ADDR_IRQMASK, 32'h5, "pre_rst_mask");
      #2 reset_n = 1'b0;
      #1;
      check("async_irq",   32'(irq0), 32'h0);
      check("async_rdata", rdata0,    32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      cycles(10);
      rd(0, ADDR_EDGECAP, 32'h0, "post_rst_cap");
      rd(0, ADDR_IRQMASK, 32'h0, "post_rst_mask");
      check("post_rst_irq", 32'(irq0), 32'h0);
      check("post_rst_irq1", 32'(irq1), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
